// File: rtl/serial_word_receiver.sv
// serial_word_receiver: start bit, WIDTH data bits (LSB- or MSB-first) and stop bit in, valid/ready word out.
// Define PARITY_EN to add an even-parity bit after the data bits and a sticky parity_err output.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun,
`ifdef PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             dir_q;
  logic             par_bad;
  logic             start_hit;
  logic             last_data;
  logic             stop_hit;

  assign start_hit = (state == S_IDLE) && sin_valid && !sin;
  assign last_data = (state == S_DATA) && sin_valid && (cnt == CW'(WIDTH - 1));
  assign stop_hit  = (state == S_STOP) && sin_valid;
  assign busy      = (state != S_IDLE);

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_hit) state_nxt = S_DATA;
`ifdef PARITY_EN
      S_DATA: if (last_data) state_nxt = S_PARITY;
`else
      S_DATA: if (last_data) state_nxt = S_STOP;
`endif
      S_PARITY: if (sin_valid) state_nxt = S_STOP;
      S_STOP:   if (sin_valid) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt        <= '0;
      shreg      <= '0;
      dir_q      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start_hit) begin
        dir_q <= dir;
        cnt   <= '0;
      end

      // LSB-first streams enter at the top and walk down; MSB-first enter at the bottom and walk up.
      if ((state == S_DATA) && sin_valid) begin
        if (dir_q) shreg <= {shreg[WIDTH-2:0], sin};
        else       shreg <= {sin, shreg[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end

      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      // A good word may replace one that is being accepted on this same edge, so there is no bubble.
      if (stop_hit) begin
        if (!sin) begin
          frame_err <= 1'b1;
        end else if (!par_bad) begin
          if (!dout_valid || dout_ready) begin
            dout       <= shreg;
            dout_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_hit) par_bad <= 1'b0;
      if ((state == S_PARITY) && sin_valid && ((^shreg) ^ sin)) begin
        par_bad    <= 1'b1;
        parity_err <= 1'b1;
      end
    end
  end
`else
  assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: directed scenarios plus randomized frames against a queue model.
// Build with PARITY_EN defined to also exercise the parity bit.
module tb_serial_word_receiver;

  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             sin;
  logic             sin_valid;
  logic             dir;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;
  logic             busy;

  int errors = 0;
  int checks = 0;

  logic             sb_on = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  serial_word_receiver #(.WIDTH(WIDTH)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dir        (dir),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

`ifndef PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 Clk = ~Clk;

  // One clock with the given line values; outputs are observed 1 time unit after the edge.
  task automatic step(input logic b, input logic v);
    sin       = b;
    sin_valid = v;
    @(posedge Clk);
    #1;
    if (sb_on && dout_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got dout=%h with no word expected", dout);
      end else begin
        if (dout !== exp_q[0]) begin
          errors++;
          $display("FAIL sb_word: got dout=%h expected %h", dout, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    Reset_n = 1'b1;
  endtask

  // One valid bit followed by 0..gapmax cycles of sin_valid=0 carrying junk.
  task automatic drive_bit(input logic b, input int gapmax);
    step(b, 1'b1);
    repeat ($urandom_range(0, gapmax)) step(1'($urandom), 1'b0);
  endtask

  // Start bit, data bits in the chosen order, and the parity bit when the feature is built in.
  task automatic send_head(input logic [WIDTH-1:0] data, input logic d, input logic par_wrong,
                           input int gapmax);
    dir = d;
    drive_bit(1'b0, gapmax);
    dir = 1'($urandom);
    for (int k = 0; k < WIDTH; k++)
      drive_bit(d ? data[WIDTH-1-k] : data[k], gapmax);
`ifdef PARITY_EN
    drive_bit((^data) ^ par_wrong, gapmax);
`endif
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] data, input logic d, input logic stop,
                            input int gapmax);
    send_head(data, d, 1'b0, gapmax);
    drive_bit(stop, gapmax);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout !== '0)        begin errors++; $display("FAIL rst_dout: got %h expected 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", dout_valid); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_ferr: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL rst_ovr: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    // Leave a word on dout, then abort a second frame after two data bits.
    dout_ready = 1'b0;
    send_frame(4'h6, 1'b0, 1'b1, 0);
    checks++; if (dout !== 4'h6) begin errors++; $display("FAIL pre_rst_word: got %h expected 6", dout); end
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    Reset_n = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    Reset_n = 1'b1;
    checks++;
    if ({dout, dout_valid, frame_err, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_outs: got dout=%h v=%b fe=%b ov=%b busy=%b expected all 0",
               dout, dout_valid, frame_err, overrun, busy);
    end
    repeat (3) step(1'b1, 1'b1);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got v=%b busy=%b expected 0 0", dout_valid, busy);
    end
    send_frame(4'b1101, 1'b0, 1'b1, 0);
    checks++;
    if (dout !== 4'b1101 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL postrst_word: got dout=%b v=%b expected 1101 1", dout, dout_valid);
    end
  endtask

  task automatic test_msb_first();
    int busy_cnt;
    logic [3:0] bits;
    do_reset();
    dout_ready = 1'b0;
    busy_cnt   = 0;
    bits       = 4'b1001;
    dir = 1'b1;
    step(1'b0, 1'b1);
    if (busy) busy_cnt++;
    dir = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      step(bits[k], 1'b1);
      if (busy) busy_cnt++;
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL msb_early: got v=%b expected 0", dout_valid); end
`ifdef PARITY_EN
    step(^bits, 1'b1);
    if (busy) busy_cnt++;
`endif
    step(1'b1, 1'b1);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b expected 1", dout_valid); end
    checks++; if (dout !== 4'b1001)    begin errors++; $display("FAIL msb_word: got %b expected 1001", dout); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL msb_busy_end: got %b expected 0", busy); end
`ifdef PARITY_EN
    checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL msb_busy_len: got %0d expected 6", busy_cnt); end
`else
    checks++; if (busy_cnt !== 5) begin errors++; $display("FAIL msb_busy_len: got %0d expected 5", busy_cnt); end
`endif
  endtask

  task automatic test_valid_gaps();
    logic bits[$];
    do_reset();
    dout_ready = 1'b0;
    dir = 1'b0;
    bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef PARITY_EN
    bits.push_back(1'b0);
`endif
    foreach (bits[i]) begin
      step(bits[i], 1'b1);
      step(1'($urandom), 1'b0);
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL gap_early: got v=%b expected 0", dout_valid); end
    step(1'b1, 1'b1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 4'b0011) begin
      errors++;
      $display("FAIL gap_word: got dout=%b v=%b expected 0011 1", dout, dout_valid);
    end
    step(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_frame_err();
    do_reset();
    dout_ready = 1'b1;
    send_frame(4'($urandom), 1'b0, 1'b0, 1);
    checks++; if (frame_err !== 1'b1)  begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", dout_valid); end
    send_frame(4'hA, 1'b0, 1'b1, 0);
    checks++;
    if (dout !== 4'hA || dout_valid !== 1'b1 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_next: got dout=%h v=%b fe=%b expected a 1 1", dout, dout_valid, frame_err);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    dout_ready = 1'b0;
    send_frame(4'h5, 1'b0, 1'b1, 0);
    send_frame(4'hC, 1'b0, 1'b1, 0);
    checks++;
    if (dout !== 4'h5 || dout_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop: got dout=%h v=%b ov=%b expected 5 1 1", dout, dout_valid, overrun);
    end
    do_reset();
    send_frame(4'h5, 1'b0, 1'b1, 0);
    send_head(4'hC, 1'b0, 1'b0, 0);
    dout_ready = 1'b1;
    step(1'b1, 1'b1);
    dout_ready = 1'b0;
    checks++;
    if (dout !== 4'hC || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_replace: got dout=%h v=%b ov=%b expected c 1 0", dout, dout_valid, overrun);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    do_reset();
    dout_ready = 1'b1;
    send_head(4'h7, 1'b0, 1'b1, 0);
    drive_bit(1'b1, 0);
    checks++;
    if (parity_err !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL par_bad: got pe=%b v=%b expected 1 0", parity_err, dout_valid);
    end
    send_frame(4'h7, 1'b0, 1'b1, 0);
    checks++;
    if (dout !== 4'h7 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL par_good: got dout=%h v=%b expected 7 1", dout, dout_valid);
    end
  endtask
`endif

  // Random frames with gaps and idle bits; the queue holds every word that must come out, in order.
  task automatic test_back_to_back();
    logic exp_ferr, exp_perr;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    do_reset();
    dout_ready = 1'b1;
    exp_q.delete();
    sb_on = 1'b1;
    for (int f = 0; f < 24; f++) begin
      logic [WIDTH-1:0] data;
      logic             d, stop, pw;
      data = WIDTH'($urandom);
      d    = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
`ifdef PARITY_EN
      pw   = ($urandom_range(0, 5) == 0);
`else
      pw   = 1'b0;
`endif
      if (!stop) exp_ferr = 1'b1;
      if (pw) exp_perr = 1'b1;
      if (stop && !pw) exp_q.push_back(data);
      send_head(data, d, pw, 1);
      drive_bit(stop, 1);
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b1);
    end
    repeat (3) step(1'b1, 1'b1);
    sb_on = 1'b0;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_missing: got %0d undelivered expected 0", exp_q.size()); end
    checks++; if (frame_err !== exp_ferr) begin errors++; $display("FAIL rnd_ferr: got %b expected %b", frame_err, exp_ferr); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rnd_ovr: got %b expected 0", overrun); end
    checks++; if (parity_err !== exp_perr) begin errors++; $display("FAIL rnd_perr: got %b expected %b", parity_err, exp_perr); end
  endtask

  initial begin
    Reset_n    = 1'b0;
    sin        = 1'b1;
    sin_valid  = 1'b0;
    dir        = 1'b0;
    dout_ready = 1'b0;
    test_reset();
    test_msb_first();
    test_valid_gaps();
    test_frame_err();
    test_overrun();
`ifdef PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-to-parallel receiver that closes the link driven by the team's universal shift register used as a serializer.
- Accepts one bit per qualified clock on a serial line.
- Frames the stream as start bit, WIDTH data bits, then stop bit, and rebuilds the parallel word in either bit order.
- Presents the word on a valid/ready output port, with framing and overrun error flags.

Parameters:
WIDTH, 4, data bits per frame (legal range 2..16)

Ports:
Clk        input   1      system clock, all logic on rising edge
Reset_n    input   1      synchronous active-low reset, sampled on rising Clk
sin        input   1      serial data bit
sin_valid  input   1      sin is meaningful this cycle; all FSM progress only on cycles with sin_valid=1
dir        input   1      0 = LSB-first (right-shift source), 1 = MSB-first (left-shift source); sampled at start bit
dout       output  WIDTH  received word
dout_valid output  1      dout holds an unconsumed word
dout_ready input   1      consumer accepts dout when dout_valid & dout_ready
frame_err  output  1      sticky: stop bit sampled as 0
overrun    output  1      sticky: frame completed while dout_valid=1 and not being accepted
busy       output  1      FSM not in IDLE

Behaviour:
- Reset (Reset_n=0 at a rising Clk):
  - FSM goes to IDLE.
  - dout=0, dout_valid=0, frame_err=0, overrun=0, busy=0.
  - Bit counter and shift register cleared.
  - Reset overrides everything, including a frame in progress; the partial word is discarded and never presented.
- States:
  - IDLE: on sin_valid & sin=0 (start bit), latch dir into dir_q, clear counter, go to DATA. sin=1 or sin_valid=0 stays in IDLE (line idle-high).
  - DATA: each sin_valid cycle shifts one bit into the shift register.
    - dir_q=0: new bit enters the MSB, register shifts right; after WIDTH bits the first received bit sits in bit 0.
    - dir_q=1: new bit enters the LSB, register shifts left; the first received bit ends in bit WIDTH-1.
    - Counter increments 0..WIDTH-1; after the WIDTH-th bit go to STOP (or PARITY, see optional feature).
  - STOP: on sin_valid, sample the stop bit, then return to IDLE.
    - sin=1: frame good; word is delivered (see delivery rule below).
    - sin=0: set frame_err; word is discarded; dout and dout_valid unchanged.
- busy=1 in every state except IDLE. Cycles with sin_valid=0 freeze the FSM, counter and shift register in all states.
- Output handshake:
  - Transfer occurs on a rising Clk with dout_valid & dout_ready.
  - dout_valid falls the next cycle unless a new word is delivered in the same cycle.
  - dout is held stable while dout_valid=1.
- Delivery rule at a good stop bit:
  - If dout_valid=0, or a transfer happens in the same cycle: load dout, set dout_valid=1 on the next edge. Accept and replace in one cycle is legal and gives no bubble.
  - Otherwise: drop the new word, set overrun; the old dout is kept.
- Latency: dout_valid rises on the Clk edge that samples the stop bit, so it is visible the cycle after the stop-bit cycle.
- frame_err and overrun are sticky until Reset_n. They do not block reception.
- dir changes mid-frame are ignored (dir_q is used).
- A start bit is only recognised in IDLE. The cycle after STOP is IDLE, so back-to-back frames with no idle bits are supported.

Optional Feature:
- Macro PARITY_EN.
  - Defined: a PARITY state sits between DATA and STOP. One sin_valid cycle samples an even-parity bit, so XOR of the data bits and the parity bit must be 0.
    - On mismatch: parity_err output (1 bit, sticky, reset 0) is set and the word is discarded at STOP.
    - Frame length becomes WIDTH+3 bits.
  - Undefined: no PARITY state, no parity_err port; frame is WIDTH+2 bits.

Test Plan:
1. Reset_n=0 for 2 cycles mid-frame (after 2 data bits), then stream idle 1s -> all outputs 0. The next clean frame (start, 1,0,1,1 LSB-first, stop) gives dout=4'b1101.
2. dir=1, WIDTH=4, sin_valid continuous, bits start 0, data 1,0,0,1, stop 1 -> dout=4'b1001, dout_valid rises the cycle after the stop bit, busy high for 5 cycles.
3. dir=0, bits 0,1,1,0,0,1 with sin_valid toggling 1,0 every other cycle -> dout=4'b0011, delivered only after 6 valid cycles.
4. Good frame with stop bit 0 -> frame_err=1, dout_valid stays 0. A following good frame with data 0xA LSB-first is still delivered as 0xA.
5. dout_ready=0, two back-to-back good frames 0x5 then 0xC -> dout stays 0x5, overrun=1. Repeating with dout_ready=1 on the second frame's stop-bit cycle -> dout=0xC, overrun=0.
6. PARITY_EN defined, data 0x7 LSB-first with parity bit 0 (wrong) -> parity_err=1, no dout_valid. Parity bit 1 -> dout=0x7.
